fl_div_seq: RTL and testbench
=============================

// Module: fl_div_seq
// PURPOSE
//  Iterative floating-point divider for the float processor core; replaces the single-cycle DIV path of the ALU.
//  Uses a start/busy/done handshake so the core stalls its PC during a divide. Optionally normalises operands first.
//  Word format (NBMANT+NBEXPO+1 bits): [MSB]=sign, next NBEXPO=exponent (2's compl), low NBMANT=unsigned mantissa.
//  value = (-1)^s * m * 2^e; zero is m==0.
// PARAMETERS
//  NBMANT  16  mantissa bits
//  NBEXPO   6  exponent bits (range -2^(NBEXPO-1) .. 2^(NBEXPO-1)-1)
//  NORMIN   1  1: NORM stage shifts unnormalised operands; 0: operands must have mantissa MSB set, NORM takes 1 cycle
//  SAT      1  1: exponent overflow saturates to max magnitude; 0: overflow returns zero (ovf flag still set)
// PORTS
//  clk    in   1                  clock
//  rst    in   1                  synchronous reset, active-low
//  start  in   1                  request; sampled only in IDLE
//  a      in   NBMANT+NBEXPO+1    dividend, captured on accepted start
//  b      in   NBMANT+NBEXPO+1    divisor, captured on accepted start
//  busy   out  1                  high from the accepted start edge until done is asserted
//  done   out  1                  single-cycle pulse, q valid
//  q      out  NBMANT+NBEXPO+1    quotient, held until the next done
//  dz     out  1                  divide-by-zero flag, valid with done, held
//  ovf    out  1                  exponent overflow, valid with done, held
//  unf    out  1                  exponent underflow, valid with done, held
// BEHAVIOUR
//  Reset (rst==0 at edge): state=IDLE; busy=0, done=0, q=0, dz=ovf=unf=0. Applies mid-operation and aborts it.
//  FSM IDLE->NORM->DIV->POST->IDLE; start while busy is ignored (no queueing).
//  IDLE: start=1 captures a, b; sign_q = sa^sb.
//   mb==0 -> POST with dz; ma==0 (mb!=0) -> POST with zero.
//   Otherwise -> NORM. dz takes priority when both are zero.
//  NORM (NORMIN=1): each cycle, every operand with mantissa MSB clear shifts left 1 and decrements its exponent.
//   Exits when both MSBs are set. k = max(lz(ma), lz(mb)).
//   Exponent decrement below min: set unf and go to POST.
//  DIV: restoring division of (ma<<NBMANT) by mb; one quotient bit per cycle, MSB first, NBMANT+1 cycles.
//   Q is NBMANT+1 bits; the remainder is discarded (truncation, no rounding).
//  POST: if Q[NBMANT]: m=Q>>1, e=ea-eb-NBMANT+1, else m=Q[NBMANT-1:0], e=ea-eb-NBMANT.
//   e is computed in NBEXPO+2 bits signed.
//   e>max: ovf=1; SAT=1 -> m=all ones, e=max; SAT=0 -> q=0.
//   e<min: unf=1, q=0 (sign cleared).
//   dz: q={sign_q, e=max, m=all ones}, dz=1.
//   zero result: q=0.
//   Register q and the flags; done=1 for one cycle; busy=0 the same edge; -> IDLE.
//  Latency (start edge t to done edge): normal L=NBMANT+3+k. Zero/dz L=1. NORMIN=0: k=0.
//  A new start is accepted in the cycle done is high (state is IDLE). Flags clear on each accepted start.
// STRUCTURE
//  Shared package (fl_pkg): field-slice helpers, EXP_MAX/EXP_MIN localparams from NBEXPO, FSM state encoding.
//  One sub-module fl_div_step: combinational restoring step (rem, divisor) -> (rem', qbit), width NBMANT+1.
//  Counter width $clog2(NBMANT+2); NORM is bounded by NBMANT cycles.
// TESTING (NBMANT=16, NBEXPO=6, NORMIN=1, SAT=1)
//  6/2: a={0,-13,0xC000}, b={0,-14,0x8000} -> q={0,-14,0xC000}, flags 0, done 19 cycles after start.
//  1/3: a={0,-15,0x8000}, b={0,-14,0xC000} -> q={0,-17,0xAAAA}; 3/-1 -> sign 1, mantissa unchanged.
//  Unnormalised: a={0,0,0x0003}, b={0,-15,0x8000} -> q={0,-14,0xC000}, latency 33 (k=14).
//  Divide by zero: b mantissa 0, a sign 1 -> q={1,+31,0xFFFF}, dz=1, done 1 cycle after start.
//   Also 0/x -> q=0, latency 1.
//  Overflow: a={0,31,0xFFFF}, b={0,-31,0x8000} -> ovf=1, q={0,31,0xFFFF}. SAT=0 -> q=0.
//   Underflow: a={0,-32,0x8000}, b={0,31,0xFFFF} -> unf=1, q=0.
//  Control: start held high during busy -> exactly one done per accepted start.
//   rst low mid-DIV -> busy=0 next edge, no done; back-to-back start on the done cycle is accepted.

Source files
------------

// File: rtl/fl_pkg.sv
// Shared definitions for the float processor arithmetic blocks: FSM encoding
// and exponent-range helpers derived from the exponent field width.
package fl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DIV  = 2'd2,
        S_POST = 2'd3
    } state_t;

    localparam int NBEXPO_DEF = 6;
    localparam int EXP_MAX    = (1 << (NBEXPO_DEF - 1)) - 1;
    localparam int EXP_MIN    = -(1 << (NBEXPO_DEF - 1));

    function automatic int exp_max(input int nbexpo);
        return (1 << (nbexpo - 1)) - 1;
    endfunction

    function automatic int exp_min(input int nbexpo);
        return -(1 << (nbexpo - 1));
    endfunction

    function automatic int word_width(input int nbmant, input int nbexpo);
        return nbmant + nbexpo + 1;
    endfunction

endpackage

// File: rtl/fl_div_step.sv
// One restoring-division step: compare the shifted partial remainder with the
// divisor and subtract when it fits, producing one quotient bit.
module fl_div_step #(
    parameter int W = 17
) (
    input  logic [W-1:0] rem_in,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_out,
    output logic         qbit
);

    always_comb begin
        qbit    = (rem_in >= dvs);
        rem_out = qbit ? (rem_in - dvs) : rem_in;
    end

endmodule

// File: rtl/fl_div_seq.sv
// Iterative floating-point divider: optional operand normalisation, one
// restoring quotient bit per cycle, then exponent fix-up with range flags.
module fl_div_seq
    import fl_pkg::*;
#(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NORMIN = 1,
    parameter int SAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NBMANT+NBEXPO:0]   a,
    input  logic [NBMANT+NBEXPO:0]   b,
    output logic                     busy,
    output logic                     done,
    output logic [NBMANT+NBEXPO:0]   q,
    output logic                     dz,
    output logic                     ovf,
    output logic                     unf
);

    localparam int W  = word_width(NBMANT, NBEXPO);
    localparam int EW = NBEXPO + 2;
    localparam int CW = $clog2(NBMANT + 2);

    localparam logic signed [EW-1:0]     EMAX_W   = EW'(exp_max(NBEXPO));
    localparam logic signed [EW-1:0]     EMIN_W   = EW'(exp_min(NBEXPO));
    localparam logic signed [NBEXPO-1:0] EMAX_E   = NBEXPO'(exp_max(NBEXPO));
    localparam logic signed [NBEXPO-1:0] EMIN_E   = NBEXPO'(exp_min(NBEXPO));
    localparam logic signed [EW-1:0]     NBM_W    = EW'(NBMANT);
    localparam logic [CW-1:0]            CNT_LAST = CW'(NBMANT);

    state_t state, state_nxt;

    logic                     sign_r;
    logic [NBMANT-1:0]        ma, mb;
    logic signed [NBEXPO-1:0] ea, eb;
    logic [NBMANT:0]          rem, quo;
    logic [CW-1:0]            cnt;
    logic                     is_dz, is_zero, nunf;

    logic                     a_mz, b_mz;
    logic                     a_sh, b_sh, norm_ok, norm_unf;
    logic [NBMANT:0]          rem_in, rem_nxt;
    logic                     qbit;
    logic                     qmsb;
    logic [NBMANT-1:0]        m_res;
    logic signed [EW-1:0]     ea_x, eb_x, e_post;
    logic [W-1:0]             q_nxt;
    logic                     dz_nxt, ovf_nxt, unf_nxt;
    logic                     unused_rem_msb;

    assign a_mz = (a[NBMANT-1:0] == '0);
    assign b_mz = (b[NBMANT-1:0] == '0);

    // Normalisation: shift whichever operand still lacks its MSB; the cycle
    // bound only matters for operands that slipped past the zero checks.
    always_comb begin
        a_sh     = !ma[NBMANT-1];
        b_sh     = !mb[NBMANT-1];
        norm_ok  = (NORMIN == 0) || (!a_sh && !b_sh) || (cnt == CNT_LAST);
        norm_unf = !norm_ok && ((a_sh && ea == EMIN_E) || (b_sh && eb == EMIN_E));
    end

    // The first step brings in ma[0]; the rest of the dividend is zeros.
    assign rem_in         = {rem[NBMANT-1:0], (cnt == '0) ? ma[0] : 1'b0};
    assign unused_rem_msb = rem[NBMANT];

    fl_div_step #(.W(NBMANT + 1)) u_step (
        .rem_in  (rem_in),
        .dvs     ({1'b0, mb}),
        .rem_out (rem_nxt),
        .qbit    (qbit)
    );

    always_comb begin
        qmsb   = quo[NBMANT];
        m_res  = qmsb ? quo[NBMANT:1] : quo[NBMANT-1:0];
        ea_x   = {{2{ea[NBEXPO-1]}}, ea};
        eb_x   = {{2{eb[NBEXPO-1]}}, eb};
        e_post = ea_x - eb_x - NBM_W + {{(EW-1){1'b0}}, qmsb};

        q_nxt   = {sign_r, e_post[NBEXPO-1:0], m_res};
        dz_nxt  = 1'b0;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (is_dz) begin
            q_nxt  = {sign_r, EMAX_E, {NBMANT{1'b1}}};
            dz_nxt = 1'b1;
        end else if (is_zero) begin
            q_nxt = '0;
        end else if (nunf) begin
            q_nxt   = '0;
            unf_nxt = 1'b1;
        end else if (e_post > EMAX_W) begin
            ovf_nxt = 1'b1;
            q_nxt   = (SAT != 0) ? {sign_r, EMAX_E, {NBMANT{1'b1}}} : '0;
        end else if (e_post < EMIN_W) begin
            unf_nxt = 1'b1;
            q_nxt   = '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (a_mz || b_mz) ? S_POST : S_NORM;
            S_NORM: begin
                if (norm_unf)     state_nxt = S_POST;
                else if (norm_ok) state_nxt = S_DIV;
            end
            S_DIV:  if (cnt == CNT_LAST) state_nxt = S_POST;
            S_POST: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            q       <= '0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            sign_r  <= 1'b0;
            ma      <= '0;
            mb      <= '0;
            ea      <= '0;
            eb      <= '0;
            rem     <= '0;
            quo     <= '0;
            cnt     <= '0;
            is_dz   <= 1'b0;
            is_zero <= 1'b0;
            nunf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    busy    <= 1'b1;
                    dz      <= 1'b0;
                    ovf     <= 1'b0;
                    unf     <= 1'b0;
                    sign_r  <= a[W-1] ^ b[W-1];
                    ma      <= a[NBMANT-1:0];
                    mb      <= b[NBMANT-1:0];
                    ea      <= a[W-2:NBMANT];
                    eb      <= b[W-2:NBMANT];
                    is_dz   <= b_mz;
                    is_zero <= a_mz;
                    nunf    <= 1'b0;
                    cnt     <= '0;
                end
                S_NORM: begin
                    if (norm_unf) begin
                        nunf <= 1'b1;
                    end else if (norm_ok) begin
                        cnt <= '0;
                        rem <= {2'b00, ma[NBMANT-1:1]};
                        quo <= '0;
                    end else begin
                        if (a_sh) begin
                            ma <= ma << 1;
                            ea <= ea - 1'b1;
                        end
                        if (b_sh) begin
                            mb <= mb << 1;
                            eb <= eb - 1'b1;
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    rem <= rem_nxt;
                    quo <= {quo[NBMANT-1:0], qbit};
                    cnt <= cnt + 1'b1;
                end
                S_POST: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    q    <= q_nxt;
                    dz   <= dz_nxt;
                    ovf  <= ovf_nxt;
                    unf  <= unf_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fl_div_seq.sv
// Directed bench for fl_div_seq with hand-computed quotients, flags and latencies.
module tb_fl_div_seq;

    localparam int W = 23;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, dz, ovf, unf;
    logic [W-1:0] q;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;
    int n_done;

    always #5 clk = ~clk;

    fl_div_seq #(.NBMANT(16), .NBEXPO(6), .NORMIN(1), .SAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .dz(dz), .ovf(ovf), .unf(unf)
    );

    function automatic logic [W-1:0] mkw(input logic s, input int e, input logic [15:0] m);
        logic [5:0] ev;
        ev = e[5:0];
        return {s, ev, m};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int l);
        l = 0;
        while (!done && l < 200) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", 32'({busy, done, dz, ovf, unf}), 32'h0);
        chk("reset_q", 32'(q), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 6 / 2
        start_op(mkw(0, -13, 16'hC000), mkw(0, -14, 16'h8000));
        chk("busy_after_start", 32'(busy), 32'h1);
        wait_done(lat);
        chk("q_6_2", 32'(q), 32'(mkw(0, -14, 16'hC000)));
        chk("flags_6_2", 32'({dz, ovf, unf}), 32'h0);
        chk("lat_6_2", lat, 19);
        chk("busy_at_done", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        chk("done_pulse", 32'(done), 32'h0);

        // 1 / 3, then 3 / -1 accepted on the done cycle
        start_op(mkw(0, -15, 16'h8000), mkw(0, -14, 16'hC000));
        wait_done(lat);
        chk("q_1_3", 32'(q), 32'(mkw(0, -17, 16'hAAAA)));
        chk("lat_1_3", lat, 19);
        start_op(mkw(0, -14, 16'hC000), mkw(1, -15, 16'h8000));
        chk("b2b_busy", 32'(busy), 32'h1);
        wait_done(lat);
        chk("q_3_m1", 32'(q), 32'(mkw(1, -14, 16'hC000)));
        chk("lat_b2b", lat, 19);

        // unnormalised dividend, k = 14
        start_op(mkw(0, 0, 16'h0003), mkw(0, -15, 16'h8000));
        wait_done(lat);
        chk("q_unnorm", 32'(q), 32'(mkw(0, -14, 16'hC000)));
        chk("lat_unnorm", lat, 33);

        // divide by zero
        start_op(mkw(1, 0, 16'h1234), mkw(0, 3, 16'h0000));
        wait_done(lat);
        chk("q_dz", 32'(q), 32'(mkw(1, 31, 16'hFFFF)));
        chk("flags_dz", 32'({dz, ovf, unf}), 32'h4);
        chk("lat_dz", lat, 1);

        // zero dividend
        start_op(mkw(1, 5, 16'h0000), mkw(0, 0, 16'h8000));
        wait_done(lat);
        chk("q_zero", 32'(q), 32'h0);
        chk("flags_zero", 32'({dz, ovf, unf}), 32'h0);
        chk("lat_zero", lat, 1);

        // exponent overflow, saturating
        start_op(mkw(0, 31, 16'hFFFF), mkw(0, -31, 16'h8000));
        wait_done(lat);
        chk("q_ovf", 32'(q), 32'(mkw(0, 31, 16'hFFFF)));
        chk("flags_ovf", 32'({dz, ovf, unf}), 32'h2);

        // exponent underflow in POST
        start_op(mkw(0, -32, 16'h8000), mkw(0, 31, 16'hFFFF));
        wait_done(lat);
        chk("q_unf", 32'(q), 32'h0);
        chk("flags_unf", 32'({dz, ovf, unf}), 32'h1);
        chk("lat_unf", lat, 19);

        // underflow while normalising
        start_op(mkw(0, -32, 16'h4000), mkw(0, 0, 16'h8000));
        wait_done(lat);
        chk("q_norm_unf", 32'(q), 32'h0);
        chk("flags_norm_unf", 32'({dz, ovf, unf}), 32'h1);
        chk("lat_norm_unf", lat, 2);

        // start held high while busy: only one done
        @(negedge clk);
        a      = mkw(0, -13, 16'hC000);
        b      = mkw(0, -14, 16'h8000);
        start  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
            if (i == 10) start = 1'b0;
        end
        chk("held_start_dones", n_done, 1);
        chk("held_start_q", 32'(q), 32'(mkw(0, -14, 16'hC000)));

        // reset in the middle of DIV aborts the operation
        start_op(mkw(0, -15, 16'h8000), mkw(0, -14, 16'hC000));
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_busy", 32'({busy, done}), 32'h0);
        chk("rst_mid_q", 32'(q), 32'h0);
        @(negedge clk);
        rst    = 1'b1;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        chk("rst_mid_no_done", n_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
